// File: rtl/react_recorder_pkg.sv
// Shared encodings for the reaction-time tester: controller states, player ids,
// winner codes and the recorder's divider states.
package rt_pkg;

    typedef enum logic [2:0] {
        MS_IDLE     = 3'd0,
        MS_WAIT     = 3'd1,
        MS_CLR_CNT1 = 3'd2,
        MS_START    = 3'd3,
        MS_STORAGE  = 3'd4,
        MS_CLR_CNT2 = 3'd5,
        MS_AVERAGE  = 3'd6,
        MS_COMPARE  = 3'd7
    } machine_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_A    = 2'd1,
        DIV_B    = 2'd2
    } div_state_t;

    localparam logic PLAYER_A = 1'b1;
    localparam logic PLAYER_B = 1'b0;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_A    = 2'b10;
    localparam logic [1:0] WINNER_B    = 2'b01;
    localparam logic [1:0] WINNER_TIE  = 2'b11;

    localparam logic [9:0] BEST_INIT = 10'd1023;

    function automatic logic [1:0] pick_winner(input logic [9:0] avg_a, input logic [9:0] avg_b,
                                               input logic no_rounds);
        if (no_rounds)          return WINNER_NONE;
        else if (avg_a < avg_b) return WINNER_A;
        else if (avg_b < avg_a) return WINNER_B;
        else                    return WINNER_TIE;
    endfunction

endpackage

// File: rtl/react_recorder_if.sv
// Controller-facing bus of the recorder: state/measurement inputs and result outputs.
interface react_recorder_if #(
    parameter int LOG2_ROUNDS = 2
);
    logic [2:0]             machine_state;
    logic                   player;
    logic [9:0]             react_time;
    logic                   signal_overflow;
    logic                   signal_stored;
    logic                   signal_averaged;
    logic                   signal_compared;
    logic [9:0]             avg_a;
    logic [9:0]             avg_b;
    logic [9:0]             best_a;
    logic [9:0]             best_b;
    logic [LOG2_ROUNDS:0]   cnt_a;
    logic [LOG2_ROUNDS:0]   cnt_b;
    logic [1:0]             winner;

    modport master (
        output machine_state, player, react_time, signal_overflow,
        input  signal_stored, signal_averaged, signal_compared,
        input  avg_a, avg_b, best_a, best_b, cnt_a, cnt_b, winner
    );

    modport slave (
        input  machine_state, player, react_time, signal_overflow,
        output signal_stored, signal_averaged, signal_compared,
        output avg_a, avg_b, best_a, best_b, cnt_a, cnt_b, winner
    );
endinterface

// File: rtl/react_recorder_seq_divider.sv
// Serial restoring divider: one quotient bit per cycle, SUM_W cycles per divide.
// done is raised in the cycle before the final step; quotient then shows the final result.
module seq_divider #(
    parameter int SUM_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [SUM_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic [SUM_W-1:0] quotient,
    output logic             done
);
    localparam int CNT_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0] rem;
    logic [SUM_W-1:0] quo;
    logic [SUM_W-1:0] dvs;
    logic [CNT_W-1:0] count;
    logic             busy;

    logic [SUM_W:0]   rem_sh;
    logic             ge;
    logic [SUM_W-1:0] rem_nx;
    logic [SUM_W-1:0] quo_nx;

    always_comb begin
        rem_sh = {rem, quo[SUM_W-1]};
        ge     = rem_sh >= {1'b0, dvs};
        // remainder stays below the divisor, so the top bit is always zero here
        rem_nx = ge ? SUM_W'(rem_sh - {1'b0, dvs}) : rem_sh[SUM_W-1:0];
        quo_nx = {quo[SUM_W-2:0], ge};
    end

    assign done     = busy && (count == CNT_W'(1));
    assign quotient = (dvs == '0) ? '0 : quo_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (abort) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            quo   <= dividend;
            dvs   <= divisor;
            count <= CNT_W'(SUM_W);
            busy  <= 1'b1;
        end else if (busy) begin
            rem   <= rem_nx;
            quo   <= quo_nx;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/react_recorder.sv
// Per-player reaction-time history: sum, count and best per player, serial averaging
// and winner selection, all triggered on entry into controller states.
//
// state    | meaning
// DIV_IDLE | no divide running, waiting for AVERAGE entry
// DIV_A    | dividing sum_a by cnt_a
// DIV_B    | dividing sum_b by cnt_b, pulse signal_averaged when done
module react_recorder
    import rt_pkg::*;
#(
    parameter int LOG2_ROUNDS = 2,
    parameter int OVF_TIME    = 1000
) (
    input logic             clk,
    input logic             rstn,
    react_recorder_if.slave bus
);
    localparam int SUM_W = 10 + LOG2_ROUNDS;
    localparam int CNT_W = LOG2_ROUNDS + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** LOG2_ROUNDS);

    logic [2:0]       prev_state;
    logic [SUM_W-1:0] sum_a, sum_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic [9:0]       best_a, best_b;
    logic [9:0]       avg_a, avg_b;
    logic [1:0]       winner;
    logic             stored, averaged, compared;

    div_state_t       div_state, div_next;
    logic             div_start, div_done;
    logic [SUM_W-1:0] div_dividend, div_divisor, div_quotient;
    logic [9:0]       avg_q;
    logic             load_avg_a, load_avg_b, avg_done;

    logic             entry_idle, entry_store, entry_avg, entry_cmp;
    logic [9:0]       store_v;
    logic [1:0]       winner_nx;

    assign entry_idle  = (bus.machine_state == MS_IDLE)    && (prev_state != MS_IDLE);
    assign entry_store = (bus.machine_state == MS_STORAGE) && (prev_state != MS_STORAGE);
    assign entry_avg   = (bus.machine_state == MS_AVERAGE) && (prev_state != MS_AVERAGE);
    assign entry_cmp   = (bus.machine_state == MS_COMPARE) && (prev_state != MS_COMPARE);

    assign store_v   = bus.signal_overflow ? 10'(OVF_TIME) : bus.react_time;
    assign winner_nx = pick_winner(avg_a, avg_b, (cnt_a == '0) || (cnt_b == '0));
    // averages cannot exceed the largest stored value; the clamp only keeps width explicit
    assign avg_q     = (div_quotient > SUM_W'(BEST_INIT)) ? BEST_INIT : div_quotient[9:0];

    always_comb begin
        div_next     = div_state;
        div_start    = 1'b0;
        div_dividend = sum_a;
        div_divisor  = SUM_W'(cnt_a);
        load_avg_a   = 1'b0;
        load_avg_b   = 1'b0;
        avg_done     = 1'b0;
        case (div_state)
            DIV_IDLE: begin
                if (entry_avg) begin
                    div_start = 1'b1;
                    div_next  = DIV_A;
                end
            end
            DIV_A: begin
                if (div_done) begin
                    load_avg_a   = 1'b1;
                    div_start    = 1'b1;
                    div_dividend = sum_b;
                    div_divisor  = SUM_W'(cnt_b);
                    div_next     = DIV_B;
                end
            end
            DIV_B: begin
                if (div_done) begin
                    load_avg_b = 1'b1;
                    avg_done   = 1'b1;
                    div_next   = DIV_IDLE;
                end
            end
            default: div_next = DIV_IDLE;
        endcase
        if (entry_idle) begin
            div_next   = DIV_IDLE;
            div_start  = 1'b0;
            load_avg_a = 1'b0;
            load_avg_b = 1'b0;
            avg_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) div_state <= DIV_IDLE;
        else       div_state <= div_next;
    end

    seq_divider #(.SUM_W(SUM_W)) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .start    (div_start),
        .abort    (entry_idle),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_state <= MS_IDLE;
            sum_a      <= '0;
            sum_b      <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            best_a     <= BEST_INIT;
            best_b     <= BEST_INIT;
            avg_a      <= '0;
            avg_b      <= '0;
            winner     <= WINNER_NONE;
            stored     <= 1'b0;
            averaged   <= 1'b0;
            compared   <= 1'b0;
        end else begin
            prev_state <= bus.machine_state;
            stored     <= 1'b0;
            compared   <= 1'b0;
            averaged   <= avg_done;
            if (entry_idle) begin
                sum_a  <= '0;
                sum_b  <= '0;
                cnt_a  <= '0;
                cnt_b  <= '0;
                best_a <= BEST_INIT;
                best_b <= BEST_INIT;
                avg_a  <= '0;
                avg_b  <= '0;
                winner <= WINNER_NONE;
            end else begin
                if (entry_store) begin
                    stored <= 1'b1;
                    if (bus.player == PLAYER_A && cnt_a < MAX_CNT) begin
                        sum_a <= sum_a + SUM_W'(store_v);
                        cnt_a <= cnt_a + CNT_W'(1);
                        if (store_v < best_a) best_a <= store_v;
                    end else if (bus.player == PLAYER_B && cnt_b < MAX_CNT) begin
                        sum_b <= sum_b + SUM_W'(store_v);
                        cnt_b <= cnt_b + CNT_W'(1);
                        if (store_v < best_b) best_b <= store_v;
                    end
                end
                if (load_avg_a) avg_a <= avg_q;
                if (load_avg_b) avg_b <= avg_q;
                if (entry_cmp) begin
                    compared <= 1'b1;
                    winner   <= winner_nx;
                end
            end
        end
    end

    assign bus.signal_stored   = stored;
    assign bus.signal_averaged = averaged;
    assign bus.signal_compared = compared;
    assign bus.avg_a           = avg_a;
    assign bus.avg_b           = avg_b;
    assign bus.best_a          = best_a;
    assign bus.best_b          = best_b;
    assign bus.cnt_a           = cnt_a;
    assign bus.cnt_b           = cnt_b;
    assign bus.winner          = winner;
endmodule

// File: doc/react_recorder.md
# react_recorder

Downstream consumer of the Timer in the reaction-time tester. It captures each finished `react_time` per player and keeps a per-player sum, round count and best time. On request it computes each player's truncated average with a serial divider, then declares the winner. It is driven by the main controller's `machine_state`: it acts on entry to STORAGE, AVERAGE and COMPARE, and clears its history on IDLE.

## Interface
- `LOG2_ROUNDS`, 2: max rounds per player = 2^LOG2_ROUNDS (default 4).
- `OVF_TIME`, 1000: value stored in place of `react_time` for an overflowed round (ms).
- `SUM_W` (localparam) = 10+LOG2_ROUNDS: accumulator and divider width.
- `clk`  in  1  1 kHz system clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `machine_state`  in  3  controller state: IDLE=0, WAIT=1, CLR_CNT1=2, START=3, STORAGE=4, CLR_CNT2=5, AVERAGE=6, COMPARE=7.
- `player`  in  1  current player: PLAYER_A=1, PLAYER_B=0.
- `react_time`  in  10  measured time from Timer, ms.
- `signal_overflow`  in  1  Timer overflow flag.
- `signal_stored`  out  1  1-cycle pulse: store event handled.
- `signal_averaged`  out  1  1-cycle pulse: both averages valid.
- `signal_compared`  out  1  1-cycle pulse: `winner` valid.
- `avg_a`, `avg_b`  out  10 each  truncated averages.
- `best_a`, `best_b`  out  10 each  minimum stored time.
- `cnt_a`, `cnt_b`  out  LOG2_ROUNDS+1 each  rounds stored.
- `winner`  out  2  00 none, 10 A, 01 B, 11 tie.

## Operation
- Internal `prev_state` register, reset to IDLE. An entry event occurs at an edge where the sampled `machine_state`==X and `prev_state`!=X. Holding a state therefore fires only once.
- **IDLE entry:**
  - Clear sums, counts and averages; set best to 1023; set `winner`=00.
  - Abort any division in progress; no `signal_averaged` pulse.
- **STORAGE entry:**
  - Stored value v = `signal_overflow` ? OVF_TIME : `react_time`.
  - If the selected player's cnt < 2^LOG2_ROUNDS: sum += v, cnt += 1, best = min(best, v).
  - Otherwise (full): no update.
  - `signal_stored` pulses in both cases.
- **AVERAGE entry:**
  - Start a serial restoring divide: sum_a/cnt_a, then sum_b/cnt_b.
  - Quotient truncated, written to `avg_*` (sum ≤ 4000, so it fits 10 bits).
  - cnt==0 gives avg 0, with the same latency.
  - Leaving AVERAGE mid-divide does not stop it; only IDLE entry or reset aborts.
  - A second AVERAGE entry while busy is ignored.
- **COMPARE entry:**
  - Either cnt==0 gives 00.
  - Otherwise lower avg wins (A gives 10, B gives 01); equal gives 11.
  - Uses current `avg_*` registers.
  - `signal_compared` pulses.
- Other states: no action.
- Divider FSM: DIV_IDLE → DIV_A → DIV_B → DIV_IDLE.

## Timing
- Reset (async assert): all pulses 0, avg 0, cnt 0, best 1023, winner 00, `prev_state`=IDLE, divider in DIV_IDLE.
- Store: registers update at the entry edge E0; `signal_stored` is high for the cycle after E0.
- Average:
  - E0 loads A.
  - E1..E_SUM_W iterate. At E_SUM_W, `avg_a` is written and B is loaded.
  - The next SUM_W edges iterate B. At E_2·SUM_W, `avg_b` is written and `signal_averaged`=1 for the cycle after it.
  - Default: pulse visible after edge E24.
- Compare: `winner` and `signal_compared` are registered at the entry edge.
- COMPARE entry during division: compares the stale `avg_*` values. The controller must wait for `signal_averaged`.
- Pulses are exactly one cycle and never overlap, except IDLE entry, which suppresses a pending `signal_averaged`.

## Structure
- Package `rt_pkg`: machine_state encodings, PLAYER_A/PLAYER_B, WINNER_* codes, BEST_INIT=1023. These are shared with Timer and the controller.
- Sub-module `seq_divider`:
  - Parameter SUM_W; ports `start`, `abort`, `dividend`, `divisor`, `quotient`, `done`.
  - SUM_W-cycle restoring divide; divisor 0 gives quotient 0.
  - Instantiated once and time-shared for A then B.

## Test plan
- Reset mid-run: assert `rstn`=0 asynchronously between edges → all outputs at reset values immediately.
- Player A, four STORAGE entries with 200, 300, 250, 450 → cnt_a=4, best_a=200; after AVERAGE entry, avg_a=300 and `signal_averaged` one cycle after edge E24.
- Partial round and overflow for player B:
  - Stores 100 and 201, plus one with `react_time`=37 and `signal_overflow`=1 (penalty 1000) → sum 1301, cnt_b=3, avg_b=433, best_b=100.
  - STORAGE held 5 cycles → exactly one store and one `signal_stored` pulse.
- Full: fifth A store of 10 → cnt_a stays 4, best_a stays 200, `signal_stored` still pulses.
- Compare:
  - avg_a=300, avg_b=433 → winner 10.
  - Equal averages → 11.
  - cnt_b=0 → 00.
- Abort: IDLE entered at E5 of a divide → no `signal_averaged`, all cleared; a fresh AVERAGE gives avg 0 at E24.
